// File: rtl/cache_refill_mem_responder.sv
// +----------------------------------------------------------------------------+
// | cache_refill_mem_responder: word-addressed backing store serving cache     |
// | line refills (LINE_WORDS-beat bursts) and write-through word writes.       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module cache_refill_mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LINE_LOG2  = 2,
  parameter int LATENCY    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic [LINE_LOG2-1:0] rsp_idx,
  output logic                 rsp_last,
  output logic                 wr_ack,
  output logic                 busy
);

  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int LINE_WORDS = 1 << LINE_LOG2;
  localparam int LINE_IDX_W = DEPTH_LOG2 - LINE_LOG2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  localparam logic [LINE_LOG2-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic                   we_q;
  logic [DEPTH_LOG2-1:0]  widx_q;
  logic [31:0]            wdata_q;
  logic [31:0]            words [DEPTH];

  logic                   accept;
  logic [DEPTH_LOG2-1:0]  req_widx;
  logic                   fast;
  logic                   finish;
  logic                   fin_we;
  logic [DEPTH_LOG2-1:0]  fin_widx;
  logic [31:0]            fin_wdata;
  logic [LINE_IDX_W-1:0]  fin_line;
  logic                   commit;
  logic [LINE_LOG2-1:0]   next_idx;
  logic                   unused_addr;

  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign accept      = req_valid && req_ready;
  assign req_widx    = req_addr[DEPTH_LOG2+1:2];
  assign unused_addr = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

  // A single-cycle latency completes the request on its own accept edge.
  assign fast      = (LATENCY == 1) && accept;
  assign finish    = ((state == WAIT) && (cnt == 4'd1)) || fast;
  assign fin_we    = fast ? req_we    : we_q;
  assign fin_widx  = fast ? req_widx  : widx_q;
  assign fin_wdata = fast ? req_wdata : wdata_q;
  assign fin_line  = fin_widx[DEPTH_LOG2-1:LINE_LOG2];
  assign commit    = finish && fin_we;
  assign next_idx  = rsp_idx + LINE_LOG2'(1);

  // Each word powers up holding its own byte address and is never reset.
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    logic [31:0] word = 32'(i * 4);
    always_ff @(posedge clk) begin
      if (rst_n && commit && (fin_widx == DEPTH_LOG2'(i)))
        word <= fin_wdata;
    end
    assign words[i] = word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      widx_q    <= '0;
      wdata_q   <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'd0;
      rsp_idx   <= '0;
      rsp_last  <= 1'b0;
      wr_ack    <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      if (accept) begin
        we_q    <= req_we;
        widx_q  <= req_widx;
        wdata_q <= req_wdata;
      end
      if (finish) begin
        cnt <= 4'd0;
        if (fin_we) begin
          wr_ack <= 1'b1;
          state  <= IDLE;
        end else begin
          state     <= BURST;
          rsp_valid <= 1'b1;
          rsp_idx   <= '0;
          rsp_last  <= (LINE_WORDS == 1);
          rsp_data  <= words[{fin_line, {LINE_LOG2{1'b0}}}];
        end
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
          WAIT: cnt <= cnt - 4'd1;
          BURST: begin
            if (rsp_ready) begin
              if (rsp_last) begin
                state     <= IDLE;
                rsp_valid <= 1'b0;
                rsp_last  <= 1'b0;
                rsp_idx   <= '0;
              end else begin
                rsp_idx  <= next_idx;
                rsp_last <= (next_idx == LAST_IDX);
                rsp_data <= words[{widx_q[DEPTH_LOG2-1:LINE_LOG2], next_idx}];
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/cache_refill_mem_responder.md
Name: cache_refill_mem_responder

Overview:
- Memory-side responder for the data cache. It serves line refills on a miss and write-through word writes from the cache controller.
- Holds a word-addressed backing store and accepts one request at a time over a valid/ready handshake.
- Waits a fixed access latency, then returns a refill as a LINE_WORDS beat burst with per-beat backpressure, or acknowledges a write.
- Sits between the cache miss/write path and the main-memory model in the simulation and FPGA build.

Parameters:
- DEPTH_LOG2, 8, log2 of backing store size in 32-bit words (256 words).
- LINE_LOG2, 2, log2 of words per cache line (4 words, 16 bytes).
- LATENCY, 3, cycles from request acceptance to first response beat or write ack; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = word write, 0 = line refill read.
- req_addr  input  32  byte address.
- req_wdata  input  32  write data (req_we=1).
- rsp_valid  output  1  refill beat valid.
- rsp_ready  input  1  cache accepts current beat.
- rsp_data  output  32  refill beat data.
- rsp_idx  output  LINE_LOG2  word offset of current beat within the line.
- rsp_last  output  1  current beat is the final beat of the line.
- wr_ack  output  1  one-cycle pulse: write committed.
- busy  output  1  request in progress (state != IDLE).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; req_ready=1; rsp_valid=0, rsp_data=0, rsp_idx=0, rsp_last=0, wr_ack=0, busy=0; latency counter=0.
  - Backing store is NOT cleared.
- Store init at time 0: mem[i] = i*4, so each word holds its own byte address.
- Addressing:
  - word index = req_addr[DEPTH_LOG2+1:2]; bits [1:0] ignored.
  - Upper bits ignored, so the address wraps modulo the store size.
  - Line base index = word index with the low LINE_LOG2 bits cleared.
- Acceptance: request accepted on a rising edge with req_valid && req_ready; address, we and wdata are latched at that edge.
- States:
  - IDLE: req_ready=1. On accept, load counter=LATENCY-1 and go to WAIT (both reads and writes).
  - WAIT: req_ready=0. Decrement counter each cycle. When counter==0:
    - read: go to BURST with beat index 0;
    - write: write mem[index]=wdata, pulse wr_ack for exactly one cycle, return to IDLE.
  - BURST:
    - rsp_valid=1; rsp_data=mem[base+idx] (registered); rsp_idx=idx; rsp_last=(idx==2^LINE_LOG2-1).
    - On rsp_valid && rsp_ready, advance idx.
    - On the last beat handshake, drop rsp_valid and return to IDLE.
    - While rsp_ready=0, hold rsp_data, rsp_idx and rsp_last stable.
- Timing: accept at edge N gives first beat valid (or wr_ack high) in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after acceptance. Consecutive beats with rsp_ready held high are back-to-back, one per cycle.
- Burst order is always line base first, ascending. There is no critical-word-first.
- req_valid while busy is ignored (req_ready=0). The request must be held by the requester until accepted.
- After returning to IDLE, a new request may be accepted on the very next edge.
- Read of a word written by an earlier acknowledged write returns the new data.
- Reset mid-operation: the burst or write is abandoned immediately. A write whose wr_ack has not yet pulsed is not committed; writes already acked persist.

Test Plan:
- Refill: req addr 0x24, we=0, rsp_ready=1 → accept, then after 3 cycles four consecutive beats 0x20, 0x24, 0x28, 0x2C; rsp_idx 0..3; rsp_last only on 0x2C; busy low after the last beat.
- Backpressure: same refill with rsp_ready=0 for 2 cycles during beat 1 → rsp_data holds 0x24 and rsp_idx holds 1; burst completes in 6 cycles and no beat is duplicated or skipped.
- Write then read: write 0xDEADBEEF to 0x30 → single wr_ack 3 cycles after accept. Then refill 0x3C → beats 0xDEADBEEF, 0x34, 0x38, 0x3C.
- Wrap: refill addr 0x404 (word 257 maps to index 1) → beats 0x0, 0x4, 0x8, 0xC.
- Busy: second req_valid held from the cycle after accept → req_ready=0 throughout; the request is accepted on the first edge after return to IDLE.
- Async reset: assert rst_n low between edges after beat 1 → outputs zero without a clock edge; req_ready=1 after release. A prior acked write to 0x30 still reads 0xDEADBEEF.
